// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner ids and
// the legal range of the memory access latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that did
// not own the previous access wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = OWN_CPU;
    if (&req)              grant_id = ~last_owner;
    else if (req[OWN_DBG]) grant_id = OWN_DBG;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto the single shared memory port,
// holding the strobes for MEM_LAT cycles and returning a one-cycle ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  input  logic              i_dbg_halt,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_arb_state
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic                         owner_q, last_owner_q, we_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            wdata_q;
  logic [1:0][DATA_W-1:0]       rdata_q;
  logic [1:0]                   ack_q;
  logic                         rd_q, wr_q;

  logic [1:0]                   req_elig;
  logic                         grant_valid, grant_id;
  logic                         grant, done;
  logic                         sel_we, we_nxt;
  logic [ADDR_W-1:0]            sel_addr;
  logic [DATA_W-1:0]            sel_wdata;

  // Halt only masks new CPU grants; an access already owned runs to completion.
  assign req_elig = {i_dbg_req, i_cpu_req & ~i_dbg_halt};

  rr_pick2 u_pick (
    .req         (req_elig),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = grant_id ? i_dbg_we    : i_cpu_we;
  assign sel_addr  = grant_id ? i_dbg_addr  : i_cpu_addr;
  assign sel_wdata = grant_id ? i_dbg_wdata : i_cpu_wdata;
  assign we_nxt    = grant ? sel_we : we_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (grant_valid) begin
        grant   = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (cnt_q == '0) begin
        done    = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with BUSY exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      rd_q <= (state_d == ST_BUSY) & ~we_nxt;
      wr_q <= (state_d == ST_BUSY) &  we_nxt;
      if (grant) begin
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        owner_q <= grant_id;
        cnt_q   <= CNT_INIT;
      end else if (state_q == ST_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (done) last_owner_q <= owner_q;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ack_q[p]   <= 1'b0;
        rdata_q[p] <= '0;
      end else begin
        ack_q[p] <= done & (owner_q == 1'(p));
        if (done && !we_q && owner_q == 1'(p)) rdata_q[p] <= i_mem_rdata;
      end
    end
  end

  assign o_cpu_ack   = ack_q[OWN_CPU];
  assign o_dbg_ack   = ack_q[OWN_DBG];
  assign o_cpu_rdata = rdata_q[OWN_CPU];
  assign o_dbg_rdata = rdata_q[OWN_DBG];
  assign o_cpu_stall = i_cpu_req & ~ack_q[OWN_CPU];
  assign o_mem_read  = rd_q;
  assign o_mem_write = wr_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_arb_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_halt = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    arb_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata), .i_dbg_halt(dbg_halt),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_arb_state(arb_state)
  );

  // Memory is a fixed address-to-data pattern; 0x10 holds a recognisable word.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  // Transaction model: ph = 0 idle, 1..LAT strobe cycles, LAT+1 ack cycle.
  int          ph;
  logic        m_own, m_last, m_we, ce, de;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rd [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; m_own = 1'b0; m_last = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    end else if (ph == 0) begin
      ce = cpu_req && !dbg_halt;
      de = dbg_req;
      if (ce || de) begin
        m_own   = (ce && de) ? !m_last : de;
        m_we    = m_own ? dbg_we    : cpu_we;
        m_addr  = m_own ? dbg_addr  : cpu_addr;
        m_wdata = m_own ? dbg_wdata : cpu_wdata;
        ph = 1;
      end
    end else if (ph <= LAT) begin
      if (ph == LAT) begin
        if (!m_we) m_rd[m_own] = mem_f(m_addr);
        m_last = m_own;
      end
      ph = ph + 1;
    end else begin
      ph = 0;
    end
  end

  int n_chk = 0, n_fail = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    logic strobe, e_cack, e_dack;
    strobe = (ph >= 1 && ph <= LAT);
    e_cack = (ph == LAT + 1) && (m_own == 1'b0);
    e_dack = (ph == LAT + 1) && (m_own == 1'b1);
    check("mem_read",  32'(mem_read),  32'(strobe && !m_we));
    check("mem_write", 32'(mem_write), 32'(strobe && m_we));
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("cpu_ack",   32'(cpu_ack), 32'(e_cack));
    check("dbg_ack",   32'(dbg_ack), 32'(e_dack));
    check("cpu_rdata", cpu_rdata, m_rd[0]);
    check("dbg_rdata", dbg_rdata, m_rd[1]);
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cack));
    check("arb_state", 32'(arb_state), (ph == 0) ? 32'd0 : (ph <= LAT) ? 32'd1 : 32'd2);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    if (rst_n) compare_all();
    #1;
  endtask

  task automatic wait_ack(output int who);
    who = -1;
    for (int i = 0; i < 40 && who < 0; i++) begin
      tick();
      if (cpu_ack)      who = 0;
      else if (dbg_ack) who = 1;
    end
    if (who < 0) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: no ack within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int who, c0, r0, w0;
    int ack_cyc [4];
    int ack_who [4];

    do_reset();
    check("reset_state", 32'(arb_state), 32'd0);
    check("reset_acks",  32'({cpu_ack, dbg_ack, mem_read, mem_write}), 32'd0);
    check("reset_rdata", cpu_rdata | dbg_rdata, 32'd0);

    // Lone CPU read of 0x10.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    c0 = cyc; r0 = rd_cnt;
    wait_ack(who);
    check("t1_owner", 32'(who), 32'd0);
    check("t1_latency", 32'(cyc - c0), 32'd3);
    check("t1_rd_cycles", 32'(rd_cnt - r0), 32'd2);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t1_stall_in_ack", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    tick();

    // Contention after reset: CPU first, then strict alternation.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30;
    for (int k = 0; k < 4; k++) begin
      wait_ack(who);
      ack_who[k] = who; ack_cyc[k] = cyc;
    end
    check("t2_order0", 32'(ack_who[0]), 32'd0);
    check("t2_order1", 32'(ack_who[1]), 32'd1);
    check("t2_order2", 32'(ack_who[2]), 32'd0);
    check("t2_order3", 32'(ack_who[3]), 32'd1);
    for (int k = 1; k < 4; k++) check("t2_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();

    // Debug write under halt while the CPU waits for a read.
    dbg_halt = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h1234_5678;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    w0 = wr_cnt;
    tick();
    check("t3_wr_addr", mem_addr, 32'h40);
    check("t3_wr_data", mem_wdata, 32'h1234_5678);
    wait_ack(who);
    check("t3_owner", 32'(who), 32'd1);
    check("t3_wr_cycles", 32'(wr_cnt - w0), 32'd2);
    check("t3_dbg_rdata_kept", dbg_rdata, mem_f(32'h30));
    dbg_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_stall_halted", 32'(cpu_stall), 32'd1);
    end
    dbg_halt = 1'b0;
    wait_ack(who);
    check("t3_cpu_after_halt", 32'(who), 32'd0);
    cpu_req = 1'b0;
    tick();

    // Address changes after grant must not reach the memory port.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
    tick();
    cpu_addr = 32'hC;
    check("t4_addr_a", mem_addr, 32'h8);
    tick();
    check("t4_addr_b", mem_addr, 32'h8);
    check("t4_read_b", 32'(mem_read), 32'd1);
    wait_ack(who);
    check("t4_rdata", cpu_rdata, mem_f(32'h8));
    cpu_req = 1'b0;
    tick();

    // Reset in the middle of a CPU access.
    cpu_req = 1'b1; cpu_addr = 32'h50;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_strobe_drop", 32'({mem_read, mem_write}), 32'd0);
    check("t5_state", 32'(arb_state), 32'd0);
    check("t5_no_ack", 32'({cpu_ack, dbg_ack}), 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h54;
    tick();
    rst_n = 1'b1;
    wait_ack(who);
    check("t5_cpu_first", 32'(who), 32'd0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick(); tick(); tick();

    // Debug write then CPU read back-to-back.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h60; dbg_wdata = 32'hCAFE_0001;
    wait_ack(who);
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60;
    wait_ack(who);
    check("t6_owner", 32'(who), 32'd0);
    check("t6_cpu_rdata", cpu_rdata, mem_f(32'h60));
    check("t6_dbg_rdata_kept", dbg_rdata, 32'd0);
    cpu_req = 1'b0;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (cpu_ack && $urandom_range(0, 1) == 0) cpu_req = 1'b0;
      if (dbg_ack && $urandom_range(0, 1) == 0) dbg_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom & 32'hFFC; cpu_wdata = $urandom;
      end
      if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = $urandom & 32'hFFC; dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 40) == 0) cpu_req = 1'b0;
      if ($urandom_range(0, 15) == 0) dbg_halt = ~dbg_halt;
    end
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_halt = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
